// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the lane dispatch/VRF read side, alu_issue_ctrl and the lane ALU.
// Macro ALU_ISSUE_PERF_CNT_EN adds the perf_busy_o / perf_stall_o counter outputs.
interface alu_issue_ctrl_if #(
  parameter int PARALLEL_IF_NUM = 4,
  parameter int OP_WIDTH        = 32,
  parameter int VL_WIDTH        = 12
);
  logic                                start_i;
  logic [VL_WIDTH-1:0]                 vl_i;
  logic [1:0]                          sew_i;
  logic [8:0]                          opmode_i;
  logic                                reduction_i;
  logic                                op_vld_i;
  logic                                op_rdy_o;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] op_a_i;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] op_b_i;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] op_c_i;
  logic                                stall_i;
  logic [PARALLEL_IF_NUM-1:0]          alu_vld_o;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] alu_a_o;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] alu_b_o;
  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] alu_c_o;
  logic [PARALLEL_IF_NUM*9-1:0]        alu_opmode_o;
  logic [PARALLEL_IF_NUM*2-1:0]        sew_o;
  logic [PARALLEL_IF_NUM-1:0]          alu_reduction_o;
  logic [PARALLEL_IF_NUM-1:0]          alu_vld_i;
  logic                                busy_o;
  logic                                done_o;
  logic                                err_o;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0]                         perf_busy_o;
  logic [31:0]                         perf_stall_o;
`endif

  modport master (
    output start_i, vl_i, sew_i, opmode_i, reduction_i, op_vld_i, op_a_i, op_b_i, op_c_i,
    output stall_i, alu_vld_i,
    input  op_rdy_o, alu_vld_o, alu_a_o, alu_b_o, alu_c_o, alu_opmode_o, sew_o,
    input  alu_reduction_o, busy_o, done_o, err_o
`ifdef ALU_ISSUE_PERF_CNT_EN
    , input perf_busy_o, perf_stall_o
`endif
  );

  modport slave (
    input  start_i, vl_i, sew_i, opmode_i, reduction_i, op_vld_i, op_a_i, op_b_i, op_c_i,
    input  stall_i, alu_vld_i,
    output op_rdy_o, alu_vld_o, alu_a_o, alu_b_o, alu_c_o, alu_opmode_o, sew_o,
    output alu_reduction_o, busy_o, done_o, err_o
`ifdef ALU_ISSUE_PERF_CNT_EN
    , output perf_busy_o, perf_stall_o
`endif
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one vector instruction's operand beats onto the lane ALU interfaces and tracks results in flight.
// Macro ALU_ISSUE_PERF_CNT_EN adds saturating busy/stall cycle counters.
module alu_issue_ctrl #(
  parameter int PARALLEL_IF_NUM = 4,
  parameter int OP_WIDTH        = 32,
  parameter int VL_WIDTH        = 12,
  parameter int INFL_WIDTH      = 4
) (
  input logic             clk,
  input logic             rstn,
  alu_issue_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start_i; latches vl and config
  // ISSUE | accepting operand beats until rem is exhausted
  // DRAIN | every beat issued; waiting for in-flight results
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int                  DW       = PARALLEL_IF_NUM * OP_WIDTH;
  localparam logic [INFL_WIDTH-1:0] INFL_MAX = '1;
  localparam logic [VL_WIDTH-1:0]   PIF_VL   = VL_WIDTH'(PARALLEL_IF_NUM);

  state_t                     state;
  logic [VL_WIDTH-1:0]        rem;
  logic [INFL_WIDTH-1:0]      infl;
  logic [8:0]                 opmode_q;
  logic [1:0]                 sew_q;
  logic                       red_q;
  logic [PARALLEL_IF_NUM-1:0] vld_q;
  logic [DW-1:0]              a_q;
  logic [DW-1:0]              b_q;
  logic [DW-1:0]              c_q;
  logic                       err_q;
  logic                       op_rdy;
  logic                       accept;
  logic                       ret;
  logic                       done;

  assign op_rdy = (state == ISSUE) && !bus.stall_i && (infl != INFL_MAX);
  assign accept = bus.op_vld_i && op_rdy;
  assign ret    = bus.alu_vld_i[0];
  assign done   = (state == DRAIN) && (infl == '0) && !ret;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rem      <= '0;
      infl     <= '0;
      opmode_q <= '0;
      sew_q    <= '0;
      red_q    <= 1'b0;
      vld_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            rem      <= bus.vl_i;
            opmode_q <= bus.opmode_i;
            sew_q    <= bus.sew_i;
            red_q    <= bus.reduction_i;
            state    <= (bus.vl_i == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (rem <= PIF_VL) begin
              rem   <= '0;
              state <= DRAIN;
            end else begin
              rem <= rem - PIF_VL;
            end
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Tail masking is purely element-count based; the ALU handles sew itself.
      for (int k = 0; k < PARALLEL_IF_NUM; k++) begin
        vld_q[k] <= accept && (VL_WIDTH'(k) < rem);
      end
      if (accept) begin
        a_q <= bus.op_a_i;
        b_q <= bus.op_b_i;
        c_q <= bus.op_c_i;
      end

      if (ret && (infl == '0)) err_q <= 1'b1;
      if (accept && !ret) begin
        infl <= infl + 1'b1;
      end else if (ret && !accept && (infl != '0)) begin
        infl <= infl - 1'b1;
      end
    end
  end

  assign bus.op_rdy_o        = op_rdy;
  assign bus.alu_vld_o       = vld_q;
  assign bus.alu_a_o         = a_q;
  assign bus.alu_b_o         = b_q;
  assign bus.alu_c_o         = c_q;
  assign bus.alu_opmode_o    = {PARALLEL_IF_NUM{opmode_q}};
  assign bus.sew_o           = {PARALLEL_IF_NUM{sew_q}};
  assign bus.alu_reduction_o = {PARALLEL_IF_NUM{red_q}};
  assign bus.busy_o          = (state != IDLE);
  assign bus.done_o          = done;
  assign bus.err_o           = err_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if ((state == IDLE) && bus.start_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state != IDLE) && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 1'b1;
      if ((state == ISSUE) && bus.op_vld_i && !op_rdy && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
    end
  end

  assign bus.perf_busy_o  = perf_busy_q;
  assign bus.perf_stall_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios, then random traffic, each cycle compared
// against an element-count / outstanding-beat model of the issue controller.
module tb_alu_issue_ctrl;
  localparam int PIF      = 4;
  localparam int OPW      = 32;
  localparam int VLW      = 12;
  localparam int INFW     = 2;
  localparam int INFL_MAX = (1 << INFW) - 1;
  localparam int DW       = PIF * OPW;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.PARALLEL_IF_NUM(PIF), .OP_WIDTH(OPW), .VL_WIDTH(VLW)) bus ();

  alu_issue_ctrl #(
    .PARALLEL_IF_NUM(PIF), .OP_WIDTH(OPW), .VL_WIDTH(VLW), .INFL_WIDTH(INFW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model: an instruction is active until done; elements left and beats outstanding
  bit             m_active;
  int             m_left;
  int             m_infl;
  bit             m_err;
  logic [8:0]     m_opmode;
  logic [1:0]     m_sew;
  bit             m_red;
  logic [PIF-1:0] m_vld;
  logic [DW-1:0]  m_a, m_b, m_c;

  int done_seen, beats_seen, full_seen, tail_seen;

  task automatic model_reset();
    m_active = 0; m_left = 0; m_infl = 0; m_err = 0;
    m_opmode = '0; m_sew = '0; m_red = 0;
    m_vld = '0; m_a = '0; m_b = '0; m_c = '0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    bus.op_a_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.op_b_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.op_c_i = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cyc();
    bit rdy, ret, acc, dn;
    int n, nxt;
    @(negedge clk);
    ret = bus.alu_vld_i[0];
    rdy = m_active && (m_left > 0) && !bus.stall_i && (m_infl < INFL_MAX);
    dn  = m_active && (m_left == 0) && (m_infl == 0) && !ret;
    check("op_rdy",    DW'(bus.op_rdy_o),        DW'(rdy));
    check("busy",      DW'(bus.busy_o),          DW'(m_active));
    check("done",      DW'(bus.done_o),          DW'(dn));
    check("err",       DW'(bus.err_o),           DW'(m_err));
    check("alu_vld",   DW'(bus.alu_vld_o),       DW'(m_vld));
    check("alu_a",     bus.alu_a_o,              m_a);
    check("alu_b",     bus.alu_b_o,              m_b);
    check("alu_c",     bus.alu_c_o,              m_c);
    check("opmode",    DW'(bus.alu_opmode_o),    DW'({PIF{m_opmode}}));
    check("sew",       DW'(bus.sew_o),           DW'({PIF{m_sew}}));
    check("reduction", DW'(bus.alu_reduction_o), DW'({PIF{m_red}}));
    if (bus.done_o === 1'b1) done_seen++;
    if (bus.alu_vld_o !== '0) beats_seen++;
    if (bus.alu_vld_o === 4'b1111) full_seen++;
    if (bus.alu_vld_o === 4'b0011) tail_seen++;

    if (!rstn) begin
      model_reset();
    end else begin
      acc = bus.op_vld_i && rdy;
      if (acc) begin
        n = (m_left < PIF) ? m_left : PIF;
        m_vld = PIF'((1 << n) - 1);
        m_a = bus.op_a_i; m_b = bus.op_b_i; m_c = bus.op_c_i;
        m_left -= n;
      end else begin
        m_vld = '0;
      end
      if (ret && m_infl == 0) m_err = 1;
      nxt = m_infl + int'(acc) - int'(ret);
      m_infl = (nxt < 0) ? 0 : nxt;
      if (dn) begin
        m_active = 0;
      end else if (!m_active && bus.start_i) begin
        m_active = 1;
        m_left   = int'(bus.vl_i);
        m_opmode = bus.opmode_i; m_sew = bus.sew_i; m_red = bus.reduction_i;
      end
    end
    @(posedge clk);
    #1;
    rand_ops();
  endtask

  task automatic start_instr(input int vl);
    bus.start_i     = 1'b1;
    bus.vl_i        = VLW'(vl);
    bus.sew_i       = 2'($urandom_range(0, 3));
    bus.opmode_i    = 9'($urandom());
    bus.reduction_i = 1'($urandom());
    cyc();
    bus.start_i     = 1'b0;
    bus.vl_i        = VLW'($urandom());
    bus.sew_i       = 2'($urandom());
    bus.opmode_i    = 9'($urandom());
    bus.reduction_i = 1'($urandom());
  endtask

  // Keep offering beats (returning results as they come) until all elements are issued.
  task automatic issue_all(input int max_cyc);
    bus.op_vld_i = 1'b1;
    for (int i = 0; i < max_cyc && m_left > 0; i++) begin
      bus.alu_vld_i = (m_infl > 0 && $urandom_range(0, 1) == 1) ? '1 : '0;
      cyc();
    end
    bus.op_vld_i  = 1'b0;
    bus.alu_vld_i = '0;
  endtask

  task automatic drain(input int max_cyc);
    bus.op_vld_i = 1'b0;
    bus.stall_i  = 1'b0;
    for (int i = 0; i < max_cyc && m_active; i++) begin
      bus.alu_vld_i = (m_infl > 0) ? '1 : '0;
      cyc();
    end
    bus.alu_vld_i = '0;
    check("drain_timeout", DW'(bus.busy_o), '0);
  endtask

  task automatic clear_counts();
    done_seen = 0; beats_seen = 0; full_seen = 0; tail_seen = 0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.start_i = 1'b0; bus.vl_i = '0; bus.sew_i = '0; bus.opmode_i = '0; bus.reduction_i = 1'b0;
    bus.op_vld_i = 1'b0; bus.stall_i = 1'b0; bus.alu_vld_i = '0;
    rand_ops();
    model_reset();
    clear_counts();
    @(posedge clk);
    #1;
    cyc();
    rstn = 1'b1;
    cyc();

    // vl=8: two full beats back to back, then two returns
    clear_counts();
    start_instr(8);
    bus.op_vld_i = 1'b1;
    cyc(); cyc();
    bus.op_vld_i = 1'b0;
    cyc();
    bus.alu_vld_i = '1;
    cyc(); cyc();
    bus.alu_vld_i = '0;
    cyc(); cyc();
    check("a_full_beats", DW'(full_seen), DW'(2));
    check("a_done_cnt",   DW'(done_seen), DW'(1));

    // vl=6: full beat then 2-element tail
    clear_counts();
    start_instr(6);
    bus.op_vld_i = 1'b1;
    cyc(); cyc();
    bus.op_vld_i = 1'b0;
    drain(20);
    check("b_full_beats", DW'(full_seen), DW'(1));
    check("b_tail_beats", DW'(tail_seen), DW'(1));

    // vl=0: straight to completion, no beats
    clear_counts();
    start_instr(0);
    cyc(); cyc();
    check("c_beats",    DW'(beats_seen), DW'(0));
    check("c_done_cnt", DW'(done_seen),  DW'(1));
    check("c_err",      DW'(bus.err_o),  DW'(0));

    // vl=12 with a 3-cycle stall after the first beat
    clear_counts();
    start_instr(12);
    bus.op_vld_i = 1'b1;
    cyc();
    bus.stall_i = 1'b1;
    cyc(); cyc(); cyc();
    bus.stall_i = 1'b0;
    issue_all(20);
    drain(20);
    check("d_beats", DW'(beats_seen), DW'(3));

    // In-flight saturation at 3 beats, then a return frees a slot
    clear_counts();
    start_instr(20);
    bus.op_vld_i = 1'b1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    check("e_sat_rdy", DW'(bus.op_rdy_o), '0);
    bus.alu_vld_i = '1;
    cyc();
    bus.alu_vld_i = '0;
    check("e_reopen_rdy", DW'(bus.op_rdy_o), DW'(1));
    issue_all(60);
    drain(30);
    check("e_beats", DW'(beats_seen), DW'(5));

    // Stray return while idle: sticky error until reset
    bus.alu_vld_i = 4'b0001;
    cyc();
    bus.alu_vld_i = '0;
    cyc(); cyc();
    start_instr(4);
    issue_all(20);
    drain(20);
    check("f_err_sticky", DW'(bus.err_o), DW'(1));
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    check("f_err_cleared", DW'(bus.err_o), '0);

    // Reset mid-instruction with two beats in flight, then a clean vl=4 instruction
    clear_counts();
    start_instr(16);
    bus.op_vld_i = 1'b1;
    cyc(); cyc();
    rstn = 1'b0;
    bus.op_vld_i = 1'b0;
    cyc();
    rstn = 1'b1;
    check("g_busy_after_rst", DW'(bus.busy_o),    '0);
    check("g_vld_after_rst",  DW'(bus.alu_vld_o), '0);
    cyc();
    start_instr(4);
    issue_all(20);
    drain(20);
    check("g_done_cnt", DW'(done_seen), DW'(1));

    // Random traffic: random vl, offers, stalls, returns and ignored mid-instruction starts
    for (int t = 0; t < 30; t++) begin
      start_instr($urandom_range(0, 40));
      for (int i = 0; i < 300 && m_active; i++) begin
        bus.op_vld_i  = 1'($urandom_range(0, 3) != 0);
        bus.stall_i   = 1'($urandom_range(0, 3) == 0);
        bus.alu_vld_i = (m_infl > 0 && $urandom_range(0, 1) == 1) ? PIF'($urandom()) | PIF'(1) : '0;
        bus.start_i   = 1'($urandom_range(0, 9) == 0);
        cyc();
      end
      bus.op_vld_i = 1'b0; bus.stall_i = 1'b0; bus.alu_vld_i = '0; bus.start_i = 1'b0;
      check("rand_timeout", DW'(bus.busy_o), '0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
